data_cache: RTL and testbench

DATA_CACHE -- requirements
Module: data_cache

---
 rtl/data_cache.sv | 126 ++++++++++++
 tb/tb_data_cache.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_cache.sv
// Direct-mapped, write-through, no-write-allocate data cache.
// Read hits return in the same cycle; misses refill a whole line word by word.
module data_cache #(
  parameter int SETS  = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic [3:0]  cpu_wstrb_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i
);

  localparam int WORD_W = $clog2(WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - 2 - WORD_W - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE} state_t;

  state_t              state, state_nxt;
  logic [WORD_W-1:0]   cnt;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_mem  [SETS];
  logic [31:0]         data_mem [SETS][WORDS];

  logic [WORD_W-1:0]   word_sel;
  logic [IDX_W-1:0]    idx;
  logic [TAG_W-1:0]    tag;
  logic                hit;
  logic                refill_ack;
  logic                refill_last;
  logic                unused_addr_bits;

  assign word_sel         = cpu_addr_i[2 +: WORD_W];
  assign idx              = cpu_addr_i[2+WORD_W +: IDX_W];
  assign tag              = cpu_addr_i[31 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign hit         = valid_q[idx] && (tag_mem[idx] == tag);
  assign refill_ack  = (state == REFILL) && mem_ack_i;
  assign refill_last = refill_ack && (cnt == WORD_W'(WORDS - 1));

  // Undefined unless a read hit is present; the pipeline ignores it otherwise.
  assign cpu_rdata_o = data_mem[idx][word_sel];

  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    state_nxt   = state;
    cpu_stall_o = 1'b0;
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = {cpu_addr_i[31:2], 2'b00};
    mem_wdata_o = cpu_wdata_i;
    mem_wstrb_o = cpu_wstrb_i;
    unique case (state)
      IDLE: begin
        if (cpu_req_i && cpu_we_i) begin
          cpu_stall_o = 1'b1;
          state_nxt   = WRITE;
        end else if (cpu_req_i && !hit) begin
          cpu_stall_o = 1'b1;
          state_nxt   = REFILL;
        end
      end
      REFILL: begin
        cpu_stall_o = 1'b1;
        mem_req_o   = 1'b1;
        mem_addr_o  = {tag, idx, cnt, 2'b00};
        mem_wstrb_o = 4'b1111;
        if (refill_last) state_nxt = IDLE;
      end
      WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        // Release the pipeline in the ack cycle so the next access starts right away.
        cpu_stall_o = !mem_ack_i;
        if (mem_ack_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        cnt <= '0;
        // Invalidate the victim up front so a half-filled line can never hit.
        if (cpu_req_i && !cpu_we_i && !hit) valid_q[idx] <= 1'b0;
      end else if (refill_ack) begin
        cnt <= cnt + 1'b1;
        if (refill_last) valid_q[idx] <= 1'b1;
      end
    end
  end

  // NOTE: tag and data arrays are not reset; the valid bits alone make stale contents harmless.
  always_ff @(posedge clk) begin
    if (refill_ack) begin
      data_mem[idx][cnt] <= mem_rdata_i;
      if (refill_last) tag_mem[idx] <= tag;
    end
    if ((state == WRITE) && mem_ack_i && hit) begin
      for (int b = 0; b < 4; b++) begin
        if (cpu_wstrb_i[b]) data_mem[idx][word_sel][8*b +: 8] <= cpu_wdata_i[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Self-checking bench for data_cache: directed scenarios plus randomized loads/stores
// compared against a line-presence model and a word-addressed backing memory.
module tb_data_cache;

  localparam int SETS  = 16;
  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req_i = 1'b0;
  logic        cpu_we_i = 1'b0;
  logic [31:0] cpu_addr_i = '0;
  logic [31:0] cpu_wdata_i = '0;
  logic [3:0]  cpu_wstrb_i = '0;
  logic [31:0] cpu_rdata_o;
  logic        cpu_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;

  int checks = 0;
  int failures = 0;

  data_cache #(.SETS(SETS), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
    .cpu_wdata_i(cpu_wdata_i), .cpu_wstrb_i(cpu_wstrb_i),
    .cpu_rdata_o(cpu_rdata_o), .cpu_stall_o(cpu_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Backing memory: word address -> data; untouched words hold an address hash.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  // Cache model: which line number (addr >> 4) each set currently holds.
  bit          line_valid [SETS];
  logic [31:0] line_num   [SETS];

  // Memory responder: acks after a delay, logs every real transfer.
  int          fixed_delay = 2;
  bit          spurious_en = 1'b0;
  int          wait_cnt = 0;
  int          cur_delay = 2;
  bit          real_ack = 1'b0;
  logic [31:0] resp_w;
  logic [31:0] rd_q[$];
  logic [31:0] wr_a_q[$];
  logic [31:0] wr_d_q[$];
  logic [3:0]  wr_s_q[$];

  always @(negedge clk) begin
    mem_ack_i = 1'b0;
    real_ack  = 1'b0;
    if (!rst_n || !mem_req_o) begin
      wait_cnt = 0;
      if (spurious_en && rst_n && $urandom_range(7) == 0) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = $urandom;
      end
    end else if (wait_cnt >= cur_delay) begin
      mem_ack_i = 1'b1;
      real_ack  = 1'b1;
      wait_cnt  = 0;
      cur_delay = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(3));
      if (mem_we_o) begin
        resp_w = mem_rd(mem_addr_o);
        for (int b = 0; b < 4; b++)
          if (mem_wstrb_o[b]) resp_w[8*b +: 8] = mem_wdata_o[8*b +: 8];
        mem[mem_addr_o] = resp_w;
        wr_a_q.push_back(mem_addr_o);
        wr_d_q.push_back(mem_wdata_o);
        wr_s_q.push_back(mem_wstrb_o);
      end else begin
        mem_rdata_i = mem_rd(mem_addr_o);
        rd_q.push_back(mem_addr_o);
      end
    end else begin
      wait_cnt++;
    end
  end

  task automatic clear_logs();
    rd_q.delete(); wr_a_q.delete(); wr_d_q.delete(); wr_s_q.delete();
  endtask

  task automatic do_reset();
    cpu_req_i = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int s = 0; s < SETS; s++) line_valid[s] = 1'b0;
    cur_delay = (fixed_delay >= 0) ? fixed_delay : 1;
    @(posedge clk); #1;
    clear_logs();
  endtask

  // Issues one access (entered and left at posedge+1) and scores it against the model.
  task automatic run_op(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] ws, input string name,
                        output int cycles, output logic [31:0] rd);
    logic [31:0] wa;
    logic [31:0] line;
    int          idx;
    bit          exp_hit;
    int          last_ack;
    logic [31:0] exp;
    wa = {addr[31:2], 2'b00};
    line = addr >> 4;
    idx = int'(line % SETS);
    exp_hit = line_valid[idx] && (line_num[idx] == line);
    cycles = 0;
    last_ack = 0;
    clear_logs();
    cpu_req_i = 1'b1; cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wd; cpu_wstrb_i = ws;
    do begin
      @(negedge clk); #1;
      cycles++;
      if (real_ack) last_ack = cycles;
    end while (cpu_stall_o && cycles < 300);
    rd = cpu_rdata_o;
    @(posedge clk); #1;
    cpu_req_i = 1'b0;

    checks++;
    if (cycles >= 300) begin
      failures++; $display("FAIL %s timeout: stall still %b after %0d cycles, want 0", name, cpu_stall_o, cycles);
    end
    if (!we) begin
      exp = mem_rd(wa);
      checks++;
      if (rd !== exp) begin failures++; $display("FAIL %s rdata: got %h want %h", name, rd, exp); end
      checks++;
      if (wr_a_q.size() != 0) begin failures++; $display("FAIL %s load wrote memory: got %0d writes want 0", name, wr_a_q.size()); end
      if (exp_hit) begin
        checks++;
        if (rd_q.size() != 0 || cycles != 1) begin
          failures++; $display("FAIL %s hit: got reads=%0d cycles=%0d want reads=0 cycles=1", name, rd_q.size(), cycles);
        end
      end else begin
        checks++;
        if (rd_q.size() != WORDS) begin
          failures++; $display("FAIL %s refill reads: got %0d want %0d", name, rd_q.size(), WORDS);
        end else begin
          for (int i = 0; i < WORDS; i++) begin
            checks++;
            if (rd_q[i] !== (line << 4) + 32'(4 * i)) begin
              failures++; $display("FAIL %s refill addr[%0d]: got %h want %h", name, i, rd_q[i], (line << 4) + 32'(4 * i));
            end
          end
        end
        checks++;
        if (cycles != last_ack + 1) begin
          failures++; $display("FAIL %s miss latency: got %0d cycles want last ack %0d + 1", name, cycles, last_ack);
        end
        line_valid[idx] = 1'b1;
        line_num[idx] = line;
      end
    end else begin
      checks++;
      if (wr_a_q.size() != 1 || rd_q.size() != 0) begin
        failures++; $display("FAIL %s store traffic: got writes=%0d reads=%0d want 1/0", name, wr_a_q.size(), rd_q.size());
      end else begin
        checks++;
        if (wr_a_q[0] !== wa || wr_d_q[0] !== wd || wr_s_q[0] !== ws) begin
          failures++; $display("FAIL %s store beat: got %h/%h/%b want %h/%h/%b", name, wr_a_q[0], wr_d_q[0], wr_s_q[0], wa, wd, ws);
        end
      end
      checks++;
      if (last_ack == 0 || cycles != last_ack) begin
        failures++; $display("FAIL %s store release: got stall drop at %0d want ack cycle %0d", name, cycles, last_ack);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    #3;
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL reset_idle: got stall=%b mem_req=%b want 0/0", cpu_stall_o, mem_req_o);
    end
    cpu_req_i = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (cpu_stall_o !== 1'b1 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL reset_req: got stall=%b mem_req=%b want 1/0", cpu_stall_o, mem_req_o);
    end
    cpu_req_i = 1'b0;
    do_reset();
    checks++;
    if (cpu_stall_o !== 1'b0 || mem_req_o !== 1'b0) begin
      failures++; $display("FAIL reset_release: got stall=%b mem_req=%b want 0/0", cpu_stall_o, mem_req_o);
    end
  endtask

  task automatic test_cold_read_hit();
    int cyc; logic [31:0] rd;
    fixed_delay = 2; spurious_en = 1'b0;
    do_reset();
    run_op(1'b0, 32'h100, '0, '0, "cold_read", cyc, rd);
    checks++;
    if (cyc != 14) begin failures++; $display("FAIL cold_read cycles: got %0d want 14", cyc); end
    run_op(1'b0, 32'h108, '0, '0, "hit_108", cyc, rd);
    checks++;
    if (rd !== mem_rd(32'h108) || cyc != 1) begin
      failures++; $display("FAIL hit_108: got %h in %0d cycles want %h in 1", rd, cyc, mem_rd(32'h108));
    end
  endtask

  task automatic test_store();
    int cyc; logic [31:0] rd; logic [31:0] old;
    old = mem_rd(32'h104);
    run_op(1'b1, 32'h104, 32'hAABBCCDD, 4'b0011, "store_hit", cyc, rd);
    run_op(1'b0, 32'h104, '0, '0, "load_after_store", cyc, rd);
    checks++;
    if (rd !== {old[31:16], 16'hCCDD} || cyc != 1) begin
      failures++; $display("FAIL store_merge: got %h in %0d cycles want %h in 1", rd, cyc, {old[31:16], 16'hCCDD});
    end
    run_op(1'b1, 32'h400, 32'h0BADF00D, 4'b1111, "store_miss", cyc, rd);
    run_op(1'b0, 32'h400, '0, '0, "load_after_store_miss", cyc, rd);
    checks++;
    if (rd !== 32'h0BADF00D || cyc != 14) begin
      failures++; $display("FAIL no_allocate: got %h in %0d cycles want 0badf00d in 14", rd, cyc);
    end
  endtask

  task automatic test_conflict();
    int cyc; logic [31:0] rd;
    run_op(1'b0, 32'h100, '0, '0, "conflict_a", cyc, rd);
    run_op(1'b0, 32'h200, '0, '0, "conflict_b", cyc, rd);
    checks++;
    if (cyc != 14) begin failures++; $display("FAIL conflict_b refill: got %0d cycles want 14", cyc); end
    run_op(1'b0, 32'h100, '0, '0, "conflict_a_again", cyc, rd);
    checks++;
    if (cyc != 14) begin failures++; $display("FAIL conflict_evict: got %0d cycles want 14", cyc); end
  endtask

  task automatic test_reset_mid_refill();
    int acks; int cyc; logic [31:0] rd;
    fixed_delay = 2; spurious_en = 1'b0;
    do_reset();
    acks = 0; cyc = 0;
    cpu_req_i = 1'b1; cpu_we_i = 1'b0; cpu_addr_i = 32'h100;
    while (acks < 2 && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      if (real_ack) acks++;
    end
    @(posedge clk); #1;
    checks++;
    if (acks != 2 || mem_req_o !== 1'b1 || mem_addr_o !== 32'h108) begin
      failures++; $display("FAIL mid_refill_setup: got acks=%0d req=%b addr=%h want 2/1/00000108", acks, mem_req_o, mem_addr_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || cpu_stall_o !== 1'b1) begin
      failures++; $display("FAIL mid_refill_reset: got mem_req=%b stall=%b want 0/1", mem_req_o, cpu_stall_o);
    end
    do_reset();
    run_op(1'b0, 32'h100, '0, '0, "reissue_after_reset", cyc, rd);
    checks++;
    if (cyc != 14) begin failures++; $display("FAIL reissue_refill: got %0d cycles want 14", cyc); end
  endtask

  task automatic test_reset_mid_write();
    int cyc; logic [31:0] rd; logic [31:0] old;
    fixed_delay = 3; spurious_en = 1'b0;
    do_reset();
    old = mem_rd(32'h180);
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 32'h180; cpu_wdata_i = 32'h55667788; cpu_wstrb_i = 4'hF;
    @(posedge clk); #1;
    checks++;
    if (mem_req_o !== 1'b1 || mem_we_o !== 1'b1 || mem_addr_o !== 32'h180) begin
      failures++; $display("FAIL mid_write_setup: got req=%b we=%b addr=%h want 1/1/00000180", mem_req_o, mem_we_o, mem_addr_o);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0) begin failures++; $display("FAIL mid_write_reset: got mem_req=%b want 0", mem_req_o); end
    do_reset();
    run_op(1'b0, 32'h180, '0, '0, "load_after_abandoned_write", cyc, rd);
    checks++;
    if (rd !== old) begin failures++; $display("FAIL abandoned_write: got %h want %h", rd, old); end
  endtask

  task automatic test_random();
    int cyc; logic [31:0] rd; logic [31:0] a; bit we;
    fixed_delay = -1; spurious_en = 1'b1;
    do_reset();
    for (int n = 0; n < 250; n++) begin
      a = ($urandom_range(3) << 8) | ($urandom_range(3) << 4) | ($urandom_range(3) << 2) | $urandom_range(3);
      we = ($urandom_range(2) == 0);
      run_op(we, a, $urandom, 4'($urandom), we ? "rand_store" : "rand_load", cyc, rd);
    end
    spurious_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_read_hit();
    test_store();
    test_conflict();
    test_reset_mid_refill();
    test_reset_mid_write();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
